// File: rtl/arp_pkg.sv
// Shared types, constants and helpers for the ARP transmit frame generator.
package arp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    PRE,
    HDR,
    BODY,
    PAD,
    FCS,
    IFG
  } arp_state_e;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE     = 16'h0001;
  localparam logic [15:0] ARP_PTYPE     = 16'h0800;
  localparam logic [7:0]  ARP_HLEN      = 8'd6;
  localparam logic [7:0]  ARP_PLEN      = 8'd4;
  localparam logic [15:0] OPER_REQ      = 16'h0001;
  localparam logic [15:0] OPER_REPLY    = 16'h0002;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam int unsigned MIN_PAYLOAD = 60;
  localparam int unsigned PRE_LEN     = 7;   // preamble bytes 1..6 plus SFD, after the grant byte
  localparam int unsigned HDR_LEN     = 14;
  localparam int unsigned BODY_LEN    = 28;
  localparam int unsigned PAD_LEN     = MIN_PAYLOAD - HDR_LEN - BODY_LEN;
  localparam int unsigned FCS_LEN     = 4;
  localparam int unsigned CNT_W       = 7;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  // Target fields captured at start and held for the whole frame.
  typedef struct packed {
    logic        reply;
    logic [47:0] dst_mac;
    logic [31:0] dst_ip;
  } arp_tgt_t;

  // One byte of reflected (LSB-first) Ethernet CRC-32.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  // Byte i of a multi-byte field, MSB byte first.
  function automatic logic [7:0] byte_of48(input logic [47:0] v, input int unsigned i);
    return 8'(v >> (8 * (5 - i)));
  endfunction

  function automatic logic [7:0] byte_of32(input logic [31:0] v, input int unsigned i);
    return 8'(v >> (8 * (3 - i)));
  endfunction

  function automatic logic [7:0] byte_of16(input logic [15:0] v, input int unsigned i);
    return 8'(v >> (8 * (1 - i)));
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC-32 register with init and enable; also exposes the next value.
module crc32_d8
  import arp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc,
  output logic [31:0] o_crc_next_c
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] crc_step;

  assign crc_step = crc32_byte(crc_q, i_data);

  // Init has priority over accumulation.
  always_comb begin
    crc_d = crc_q;
    if (i_init) begin
      crc_d = CRC_INIT;
    end else if (i_en) begin
      crc_d = crc_step;
    end
  end

  // CRC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_crc        = crc_q;
  assign o_crc_next_c = crc_step;

endmodule

// File: rtl/arp_tx_frame_gen.sv
// Builds Ethernet II ARP request/reply frames byte-by-byte for the GMII TX arbiter.
module arp_tx_frame_gen
  import arp_pkg::*;
#(
  parameter logic [47:0]  LOCAL_MAC  = 48'h00_0A_35_01_FE_C0,
  parameter logic [31:0]  LOCAL_IP   = 32'hC0_A8_01_0A,
  parameter int unsigned  IFG_CYCLES = 12
) (
  input  logic        i_gmii_clk,
  input  logic        i_sys_rstn,
  input  logic        i_arp_tx_start,
  input  logic        i_arp_tx_type,
  input  logic [47:0] i_dst_mac,
  input  logic [31:0] i_dst_ip,
  output logic        o_arp_req,
  input  logic        i_arp_valid,
  output logic        o_gmii_arp_dv,
  output logic [7:0]  o_gmii_arp_data,
  output logic        o_busy,
  output logic        o_tx_done
);

  localparam int unsigned IFG_W = $clog2(IFG_CYCLES + 1);

  arp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
  arp_tgt_t         tgt_q, tgt_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             dv_q, dv_d;
  logic [7:0]       data_q, data_d;
  logic             tx_done_q, tx_done_d;

  logic             grant_c;
  logic             crc_init;
  logic             crc_en;
  logic [31:0]      crc_q;
  logic [31:0]      crc_next_c;
  logic [31:0]      fcs_crc;

  function automatic logic in_frame(input arp_state_e st);
    return st inside {PRE, HDR, BODY, PAD, FCS};
  endfunction

  // Byte driven while in state st at byte index i.
  function automatic logic [7:0] frame_byte(input arp_state_e st, input int unsigned i,
                                            input arp_tgt_t tgt, input logic [31:0] crc);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      PRE: b = (i == PRE_LEN - 1) ? SFD_BYTE : PREAMBLE_BYTE;
      HDR: begin
        if (i < 6)       b = tgt.reply ? byte_of48(tgt.dst_mac, i) : 8'hFF;
        else if (i < 12) b = byte_of48(LOCAL_MAC, i - 6);
        else             b = byte_of16(ETH_TYPE_ARP, i - 12);
      end
      BODY: begin
        if (i < 2)       b = byte_of16(ARP_HTYPE, i);
        else if (i < 4)  b = byte_of16(ARP_PTYPE, i - 2);
        else if (i == 4) b = ARP_HLEN;
        else if (i == 5) b = ARP_PLEN;
        else if (i < 8)  b = byte_of16(tgt.reply ? OPER_REPLY : OPER_REQ, i - 6);
        else if (i < 14) b = byte_of48(LOCAL_MAC, i - 8);
        else if (i < 18) b = byte_of32(LOCAL_IP, i - 14);
        else if (i < 24) b = tgt.reply ? byte_of48(tgt.dst_mac, i - 18) : 8'h00;
        else             b = byte_of32(tgt.dst_ip, i - 24);
      end
      FCS:     b = 8'(~crc >> (8 * i));
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // The grant cycle itself carries preamble byte 0 so the arbiter never sees an idle gap.
  assign grant_c = (state_q == REQ) && i_arp_valid;

  // CRC restarts on the SFD cycle and covers header, body and pad as they go out.
  assign crc_init = (state_q == PRE) && (cnt_q == CNT_W'(PRE_LEN - 1));
  assign crc_en   = state_q inside {HDR, BODY, PAD};

  // The first FCS byte is loaded while the last pad byte is still being absorbed.
  assign fcs_crc = (state_q == FCS) ? crc_q : crc_next_c;

  crc32_d8 u_crc (
    .clk          (i_gmii_clk),
    .rst_n        (i_sys_rstn),
    .i_init       (crc_init),
    .i_en         (crc_en),
    .i_data       (data_q),
    .o_crc        (crc_q),
    .o_crc_next_c (crc_next_c)
  );

  // Next-state, counters and next output byte.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    tx_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_arp_tx_start) begin
          state_d = REQ;
          tgt_d   = '{reply: i_arp_tx_type, dst_mac: i_dst_mac, dst_ip: i_dst_ip};
        end
      end
      REQ:  if (i_arp_valid) state_d = PRE;
      PRE:  if (cnt_q == CNT_W'(PRE_LEN - 1))  state_d = HDR;
      HDR:  if (cnt_q == CNT_W'(HDR_LEN - 1))  state_d = BODY;
      BODY: if (cnt_q == CNT_W'(BODY_LEN - 1)) state_d = PAD;
      PAD:  if (cnt_q == CNT_W'(PAD_LEN - 1))  state_d = FCS;
      FCS: begin
        if (cnt_q == CNT_W'(FCS_LEN - 1)) begin
          state_d   = IFG;
          tx_done_d = 1'b1;
        end
      end
      IFG:  if (ifg_cnt_q == IFG_W'(IFG_CYCLES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)  cnt_d = '0;
    else if (in_frame(state_q)) cnt_d = cnt_q + CNT_W'(1);
    else                     cnt_d = cnt_q;

    ifg_cnt_d = ((state_q == IFG) && (state_d == IFG)) ? ifg_cnt_q + IFG_W'(1) : '0;

    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
    dv_d   = in_frame(state_d);
    data_d = frame_byte(state_d, 32'(cnt_d), tgt_d, fcs_crc);
  end

  // State and output registers.
  always_ff @(posedge i_gmii_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ifg_cnt_q <= '0;
      tgt_q     <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      dv_q      <= 1'b0;
      data_q    <= 8'h00;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ifg_cnt_q <= ifg_cnt_d;
      tgt_q     <= tgt_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      dv_q      <= dv_d;
      data_q    <= data_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign o_arp_req       = req_q;
  assign o_busy          = busy_q;
  assign o_tx_done       = tx_done_q;
  assign o_gmii_arp_dv   = dv_q | grant_c;
  assign o_gmii_arp_data = grant_c ? PREAMBLE_BYTE : data_q;

endmodule
